winograd_tile_sched: RTL and testbench

WINOGRAD_TILE_SCHED -- requirements
Module: winograd_tile_sched

---
 rtl/wino_pkg.sv | 23 ++
 rtl/winograd_tile_sched_if.sv | 33 +++
 rtl/wino_addr_gen.sv | 84 ++++++++
 rtl/winograd_tile_sched.sv | 198 +++++++++++++++++++
 tb/tb_winograd_tile_sched.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wino_pkg.sv
// rtl/wino_pkg.sv - shared FSM state type and tile geometry constants
//
// Purpose: common definitions for the Winograd F(2x2,3x3) tile scheduler.
//   wino_state_e : scheduler FSM states
//   TILE_N       : input tile elements (4x4)
//   KER_N        : kernel weights (3x3)
//   OUT_N        : output elements per tile (2x2)
package wino_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    FETCH,
    COMPUTE,
    WRITE,
    DONE_ST
  } wino_state_e;

  localparam int TILE_N = 16;
  localparam int KER_N  = 9;
  localparam int OUT_N  = 4;

endpackage

// File: rtl/winograd_tile_sched_if.sv
// rtl/winograd_tile_sched_if.sv - feature-buffer read bus and tile output handshake
//
// Purpose: bundles the buffer read port and the result output handshake.
//   rd_en/rd_addr/rd_data          : read strobe, address, data (1 cycle latency)
//   out_valid/out_ready            : result handshake
//   out_data/out_x/out_y           : 2x2 result and tile top-left coordinate
// Modports: master = scheduler side, slave = buffer/consumer side.
interface winograd_tile_sched_if import wino_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 6
) ();

  logic                      rd_en;
  logic [ADDR_W-1:0]         rd_addr;
  logic [DATA_W-1:0]         rd_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_N*DATA_W-1:0]   out_data;
  logic [DIM_W-1:0]          out_x;
  logic [DIM_W-1:0]          out_y;

  modport master (
    output rd_en, rd_addr, out_valid, out_data, out_x, out_y,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data, out_x, out_y,
    output rd_data, out_ready
  );

endinterface

// File: rtl/wino_addr_gen.sv
// rtl/wino_addr_gen.sv - tile origin counters and buffer address computation
//
// Purpose: holds the layer dimensions and the current tile origin (tx, ty),
// and forms the read address for kernel or tile fetches.
//   clk, rst_n          : clock, async active-low reset
//   load                : latch img_w/img_h, origin to (0,0)
//   step                : advance origin in raster order by 2
//   sel_ker             : 1 = kernel address, 0 = tile pixel address
//   idx                 : kernel index, or tile element index (row in [3:2], col in [1:0])
//   img_w, img_h        : layer dimensions
//   ker_base, img_base  : base addresses
//   tx, ty              : current tile origin
//   last                : current tile is the final one of the layer
//   addr                : computed read address (wraps modulo 2^ADDR_W)
module wino_addr_gen import wino_pkg::*; #(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              sel_ker,
  input  logic [3:0]        idx,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [ADDR_W-1:0] ker_base,
  input  logic [ADDR_W-1:0] img_base,
  output logic [DIM_W-1:0]  tx,
  output logic [DIM_W-1:0]  ty,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  logic [DIM_W-1:0] w_q, w_d, h_q, h_d, tx_q, tx_d, ty_q, ty_d;
  logic             row_end;
  logic [ADDR_W-1:0] row, col;

  assign row_end = (tx_q == w_q - DIM_W'(4));
  assign last    = row_end && (ty_q == h_q - DIM_W'(4));

  always_comb begin
    w_d  = w_q;
    h_d  = h_q;
    tx_d = tx_q;
    ty_d = ty_q;
    if (load) begin
      w_d  = img_w;
      h_d  = img_h;
      tx_d = '0;
      ty_d = '0;
    end else if (step) begin
      if (row_end) begin
        tx_d = '0;
        ty_d = ty_q + DIM_W'(2);
      end else begin
        tx_d = tx_q + DIM_W'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q  <= '0;
      h_q  <= '0;
      tx_q <= '0;
      ty_q <= '0;
    end else begin
      w_q  <= w_d;
      h_q  <= h_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
    end
  end

  // All terms are truncated to ADDR_W so the address wraps naturally.
  assign row  = ADDR_W'(ty_q) + ADDR_W'(idx[3:2]);
  assign col  = ADDR_W'(tx_q) + ADDR_W'(idx[1:0]);
  assign addr = sel_ker ? (ker_base + ADDR_W'(idx))
                        : (img_base + row * ADDR_W'(w_q) + col);
  assign tx   = tx_q;
  assign ty   = ty_q;

endmodule

// File: rtl/winograd_tile_sched.sv
// rtl/winograd_tile_sched.sv - Winograd F(2x2,3x3) tile fetch/issue scheduler
//
// Purpose: loads a 3x3 kernel, then walks 4x4 input tiles (stride 2) over the
// image, presents each tile to an external transform datapath and returns the
// registered 2x2 result over a valid/ready handshake.
//   clk, rst_n           : clock, async active-low reset
//   start, abort         : begin layer (IDLE only) / force IDLE
//   img_w, img_h         : image dimensions, sampled at start
//   ker_base, img_base   : base addresses of weights and image
//   bus                  : read bus + output handshake (master modport)
//   tile_o, ker_o        : registered tile and kernel to the datapath
//   res_i                : combinational 2x2 result from the datapath
//   busy, done           : not-IDLE / one-cycle end-of-layer pulse
// Optional (WINO_PERF_CNT_EN): cyc_busy, cyc_stall performance counters.
module winograd_tile_sched import wino_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DIM_W-1:0]         img_w,
  input  logic [DIM_W-1:0]         img_h,
  input  logic [ADDR_W-1:0]        ker_base,
  input  logic [ADDR_W-1:0]        img_base,
  winograd_tile_sched_if.master    bus,
  output logic [TILE_N*DATA_W-1:0] tile_o,
  output logic [KER_N*DATA_W-1:0]  ker_o,
  input  logic [OUT_N*DATA_W-1:0]  res_i,
  output logic                     busy,
  output logic                     done
`ifdef WINO_PERF_CNT_EN
  ,
  output logic [31:0]              cyc_busy,
  output logic [31:0]              cyc_stall
`endif
);

  wino_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tile_q [TILE_N];
  logic [DATA_W-1:0] ker_q  [KER_N];
  logic [OUT_N*DATA_W-1:0] out_data_q;
  logic [DIM_W-1:0]  out_x_q, out_y_q;

  logic rd_en, sel_ker, cap_k, cap_t, cap_o, ag_load, ag_step;
  logic dims_ok, last_tile;
  logic [DIM_W-1:0]  tx, ty;
  logic [ADDR_W-1:0] ag_addr;
  logic [3:0]        cap_idx;

  assign dims_ok = !img_w[0] && !img_h[0] && (img_w >= DIM_W'(4)) && (img_h >= DIM_W'(4));
  // Data for the read issued at count n arrives while the count is n+1.
  assign cap_idx = 4'(cnt_q - 5'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    sel_ker = 1'b0;
    cap_k   = 1'b0;
    cap_t   = 1'b0;
    cap_o   = 1'b0;
    ag_load = 1'b0;
    ag_step = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        ag_load = 1'b1;
        cnt_d   = '0;
        state_d = dims_ok ? LOAD_K : DONE_ST;
      end
      LOAD_K: begin
        sel_ker = 1'b1;
        rd_en   = (cnt_q < 5'(KER_N));
        cap_k   = (cnt_q != 5'd0);
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'(KER_N)) begin
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rd_en = (cnt_q < 5'(TILE_N));
        cap_t = (cnt_q != 5'd0);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(TILE_N)) begin
          cnt_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        cap_o   = 1'b1;
        state_d = WRITE;
      end
      WRITE: if (bus.out_ready) begin
        if (last_tile) begin
          state_d = DONE_ST;
        end else begin
          ag_step = 1'b1;
          state_d = FETCH;
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a start seen in IDLE.
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      cap_k   = 1'b0;
      cap_t   = 1'b0;
      cap_o   = 1'b0;
      ag_load = 1'b0;
      ag_step = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      for (int i = 0; i < TILE_N; i++) tile_q[i] <= '0;
      for (int i = 0; i < KER_N; i++)  ker_q[i]  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < KER_N; i++)
        if (cap_k && cap_idx == 4'(i)) ker_q[i] <= bus.rd_data;
      for (int i = 0; i < TILE_N; i++)
        if (cap_t && cap_idx == 4'(i)) tile_q[i] <= bus.rd_data;
      if (cap_o) begin
        out_data_q <= res_i;
        out_x_q    <= tx;
        out_y_q    <= ty;
      end
    end
  end

  wino_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ag_load),
    .step     (ag_step),
    .sel_ker  (sel_ker),
    .idx      (cnt_q[3:0]),
    .img_w    (img_w),
    .img_h    (img_h),
    .ker_base (ker_base),
    .img_base (img_base),
    .tx       (tx),
    .ty       (ty),
    .last     (last_tile),
    .addr     (ag_addr)
  );

  for (genvar g = 0; g < TILE_N; g++) begin : g_tile
    assign tile_o[g*DATA_W +: DATA_W] = tile_q[g];
  end
  for (genvar g = 0; g < KER_N; g++) begin : g_ker
    assign ker_o[g*DATA_W +: DATA_W] = ker_q[g];
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_en ? ag_addr : '0;
  assign bus.out_valid = (state_q == WRITE);
  assign bus.out_data  = out_data_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE_ST);

`ifdef WINO_PERF_CNT_EN
  logic [31:0] cyc_busy_q, cyc_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_busy_q  <= '0;
      cyc_stall_q <= '0;
    end else if (state_q == IDLE && start && !abort) begin
      cyc_busy_q  <= '0;
      cyc_stall_q <= '0;
    end else begin
      if (busy && cyc_busy_q != '1) cyc_busy_q <= cyc_busy_q + 32'd1;
      if (state_q == WRITE && !bus.out_ready && cyc_stall_q != '1)
        cyc_stall_q <= cyc_stall_q + 32'd1;
    end
  end

  assign cyc_busy  = cyc_busy_q;
  assign cyc_stall = cyc_stall_q;
`endif

endmodule

// File: tb/tb_winograd_tile_sched.sv
// tb/tb_winograd_tile_sched.sv - self-checking bench for winograd_tile_sched
module tb_winograd_tile_sched;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 12;
  localparam int DIM_W  = 6;
  localparam int MEM_N  = 1 << ADDR_W;

  logic clk, rst_n, start, abort;
  logic [DIM_W-1:0]  img_w, img_h;
  logic [ADDR_W-1:0] ker_base, img_base;
  logic [16*DATA_W-1:0] tile_o;
  logic [9*DATA_W-1:0]  ker_o;
  logic [4*DATA_W-1:0]  res_i;
  logic busy, done;
`ifdef WINO_PERF_CNT_EN
  logic [31:0] cyc_busy, cyc_stall;
`endif

  winograd_tile_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

  winograd_tile_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .img_w    (img_w),
    .img_h    (img_h),
    .ker_base (ker_base),
    .img_base (img_base),
    .bus      (bus),
    .tile_o   (tile_o),
    .ker_o    (ker_o),
    .res_i    (res_i),
    .busy     (busy),
    .done     (done)
`ifdef WINO_PERF_CNT_EN
    ,
    .cyc_busy (cyc_busy),
    .cyc_stall(cyc_stall)
`endif
  );

  logic [7:0] mem [MEM_N];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [ADDR_W-1:0] rd_q[$], exp_rd[$];
  logic [63:0] out_q[$], exp_out[$];
  int done_cnt, done_cyc, start_cyc, rdy_rand, n_tiles;
  logic hold_q;
  logic [63:0] held;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer: registered read, data valid the cycle after rd_en.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

  // Direct 2x2 convolution of a 4x4 tile with a 3x3 kernel, truncated to 8 bits.
  function automatic logic [31:0] conv(input logic [127:0] t, input logic [71:0] k);
    logic [31:0] r;
    int acc;
    r = '0;
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 2; xx++) begin
        acc = 0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            acc += int'(t[((yy+rr)*4 + xx + cc)*8 +: 8]) * int'(k[(rr*3 + cc)*8 +: 8]);
        r[(yy*2 + xx)*8 +: 8] = acc[7:0];
      end
    return r;
  endfunction

  assign res_i = conv(tile_o, ker_o);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: observe the current cycle at negedge, return 1ns after the next posedge.
  task automatic tick();
    @(negedge clk);
    if (bus.rd_en) rd_q.push_back(bus.rd_addr);
    if (bus.out_valid && bus.out_ready)
      out_q.push_back({20'b0, bus.out_x, bus.out_y, bus.out_data});
    if (hold_q && bus.out_valid)
      check_eq("hold", {20'b0, bus.out_x, bus.out_y, bus.out_data}, held);
    hold_q = bus.out_valid && !bus.out_ready && rst_n;
    held   = {20'b0, bus.out_x, bus.out_y, bus.out_data};
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (rdy_rand != 0) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic build_exp(input int w, input int h, input int kb, input int ib);
    logic [127:0] t;
    logic [71:0]  k;
    int a;
    exp_rd.delete();
    exp_out.delete();
    t = '0;
    k = '0;
    for (int i = 0; i < 9; i++) begin
      a = (kb + i) % MEM_N;
      exp_rd.push_back(ADDR_W'(a));
      k[i*8 +: 8] = mem[a];
    end
    for (int ty = 0; ty <= h - 4; ty += 2)
      for (int tx = 0; tx <= w - 4; tx += 2) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            a = (ib + (ty + r) * w + tx + c) % MEM_N;
            exp_rd.push_back(ADDR_W'(a));
            t[(r*4 + c)*8 +: 8] = mem[a];
          end
        exp_out.push_back({20'b0, DIM_W'(tx), DIM_W'(ty), conv(t, k)});
      end
    n_tiles = exp_out.size();
  endtask

  task automatic start_layer(input int w, input int h, input int kb, input int ib);
    build_exp(w, h, kb, ib);
    rd_q.delete();
    out_q.delete();
    done_cnt = 0;
    img_w    = DIM_W'(w);
    img_h    = DIM_W'(h);
    ker_base = ADDR_W'(kb);
    img_base = ADDR_W'(ib);
    start    = 1'b1;
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic finish_layer(input int timed, input int inject);
    for (int i = 0; i < 20000; i++) begin
      if (done_cnt != 0) break;
      start = (inject != 0) && busy && ($urandom_range(0, 15) == 0);
      tick();
    end
    start = 1'b0;
    tick();
    check_eq("done_pulses", done_cnt, 1);
    check_eq("idle_after", busy, 0);
    if (timed != 0) check_eq("latency", done_cyc - start_cyc, 10 + 19 * n_tiles);
    check_eq("rd_count", rd_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      check_eq($sformatf("rd_addr%0d", i), rd_q[i], exp_rd[i]);
    check_eq("out_count", out_q.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < out_q.size(); i++)
      check_eq($sformatf("out%0d", i), out_q[i], exp_out[i]);
  endtask

  task automatic run_layer(input int w, input int h, input int kb, input int ib, input int mode);
    rdy_rand = mode;
    bus.out_ready = 1'b1;
    start_layer(w, h, kb, ib);
    finish_layer(mode == 0, mode);
    rdy_rand = 0;
  endtask

  initial begin
    int sizes[5] = '{4, 6, 8, 10, 12};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    img_w = '0; img_h = '0; ker_base = '0; img_base = '0;
    bus.out_ready = 1'b0;
    rdy_rand = 0; hold_q = 1'b0; held = '0; done_cnt = 0;
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'(i);
    repeat (3) tick();

    check_eq("rst_rd_en", bus.rd_en, 0);
    check_eq("rst_rd_addr", bus.rd_addr, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_out_xy", {bus.out_x, bus.out_y}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_tile", tile_o != '0, 0);
    check_eq("rst_ker", ker_o != '0, 0);
    rst_n = 1'b1;
    tick();

    // 4x4 with buffer[i]=i, then 6x6 raster order on random data.
    run_layer(4, 4, 200, 0, 0);
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'($urandom);
    run_layer(6, 6, 1000, 2000, 0);

    // Output held for 5 stalled WRITE cycles.
    bus.out_ready = 1'b0;
    start_layer(4, 4, 30, 500);
    for (int i = 0; i < 200 && !bus.out_valid; i++) tick();
    check_eq("stall_reach", bus.out_valid, 1);
    repeat (5) tick();
    check_eq("stall_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    finish_layer(0, 0);
`ifdef WINO_PERF_CNT_EN
    check_eq("cyc_stall", cyc_stall, 5);
    check_eq("cyc_busy", cyc_busy, 35);
`endif

    // Random layers, random backpressure, stray starts while busy, wrapping bases.
    for (int n = 0; n < 5; n++)
      run_layer(sizes[$urandom_range(0, 4)], sizes[$urandom_range(0, 4)],
                $urandom_range(0, MEM_N - 1),
                (n == 0) ? MEM_N - 20 : $urandom_range(0, MEM_N - 1), 1);

    // Abort in the 7th FETCH cycle of tile 2.
    bus.out_ready = 1'b1;
    start_layer(6, 6, 7, 77);
    for (int i = 0; i < 200 && rd_q.size() < 31; i++) tick();
    check_eq("abort_reach", rd_q.size() >= 31, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valid", bus.out_valid, 0);
    check_eq("abort_rd_en", bus.rd_en, 0);
    repeat (5) tick();
    check_eq("abort_no_done", done_cnt, 0);
    run_layer(4, 4, 40, 400, 0);

    // start together with abort in IDLE.
    done_cnt = 0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("start_abort_busy", busy, 0);
    tick();
    check_eq("start_abort_done", done_cnt, 0);

    // Invalid dimensions: immediate done, no reads, no outputs.
    for (int n = 0; n < 2; n++) begin
      rd_q.delete();
      out_q.delete();
      done_cnt = 0;
      img_w = (n == 0) ? 6'd5 : 6'd6;
      img_h = (n == 0) ? 6'd6 : 6'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("bad_done", done, 1);
      tick();
      check_eq("bad_idle", busy, 0);
      check_eq("bad_reads", rd_q.size(), 0);
      check_eq("bad_outs", out_q.size(), 0);
      check_eq("bad_done_cnt", done_cnt, 1);
    end

    // Reset during WRITE, then a fresh layer starts from (0,0).
    bus.out_ready = 1'b0;
    start_layer(6, 6, 50, 600);
    for (int i = 0; i < 200 && !bus.out_valid; i++) tick();
    check_eq("rstw_reach", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rstw_valid", bus.out_valid, 0);
    check_eq("rstw_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_layer(4, 4, 60, 700, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
